// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared constants for the stopwatch control slice: FSM state
//               encodings, counter field widths and default timing values.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  // FSM state encodings; also the value presented on the state output
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LAP   = 2'd3;

  // Counter field widths (values 0..59)
  localparam int SEC_W = 6;
  localparam int MIN_W = 6;

  // Defaults for a ~12 MHz clock: 1 s tick, 10 ms debounce
  localparam int TICK_DIV_DEFAULT        = 12000000;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 120000;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer, consecutive-sample debouncer and
//               rising-edge press pulse for one raw push-button.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Next-state: accept a new level only after DEBOUNCE_CYCLES disagreeing samples
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Pulse is registered together with the level change, so it lasts one cycle
    press_d = level_d & ~level_q;
  end

  // State registers for synchronizer, debouncer and press pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch control sequencer: button conditioning, run/pause/
//               lap/idle FSM, 1 Hz tick prescaler, counter clear and lap
//               freeze of the display value.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV        = TICK_DIV_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic             btn_lap,
  input  logic [SEC_W-1:0] sec_in,
  input  logic [MIN_W-1:0] min_in,
  output logic             tick,
  output logic             clr,
  output logic [SEC_W-1:0] disp_sec,
  output logic [MIN_W-1:0] disp_min,
  output logic             lap_active,
  output logic [1:0]       state
);

  localparam int               PRESC_W   = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  logic press_start, press_stop, press_lap;
  logic start_p, stop_p, lap_p;
  logic running;

  logic [1:0]         state_q,   state_d;
  logic [PRESC_W-1:0] presc_q,   presc_d;
  logic               tick_q,    tick_d;
  logic               clr_q,     clr_d;
  logic [SEC_W-1:0]   lap_sec_q, lap_sec_d;
  logic [MIN_W-1:0]   lap_min_q, lap_min_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_start), .press(press_start)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_stop), .press(press_stop)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_lap), .press(press_lap)
  );

  // Press arbitration: stop beats start beats lap; losers are discarded
  always_comb begin
    stop_p  = press_stop;
    start_p = press_start & ~press_stop;
    lap_p   = press_lap & ~press_stop & ~press_start;
  end

  // FSM, prescaler, lap latch and registered tick/clr next-state logic
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    lap_sec_d = lap_sec_q;
    lap_min_d = lap_min_q;
    clr_d     = 1'b0;
    running   = (state_q == ST_RUN) || (state_q == ST_LAP);

    // Prescaler advances only while counting; PAUSE keeps the partial second
    if (running) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_p) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
      end
      ST_RUN: begin
        if (stop_p) begin
          state_d = ST_PAUSE;
        end else if (lap_p) begin
          state_d   = ST_LAP;
          lap_sec_d = sec_in;
          lap_min_d = min_in;
        end
      end
      ST_LAP: begin
        if (stop_p) begin
          state_d = ST_PAUSE;
        end else if (lap_p) begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (start_p) begin
          state_d = ST_RUN;
        end else if (lap_p) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Tick is registered so it coincides with the terminal prescaler value;
    // clr only occurs on entry to IDLE, where tick cannot be asserted
    tick_d = ((state_d == ST_RUN) || (state_d == ST_LAP)) && (presc_d == PRESC_MAX);
  end

  // Controller state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      clr_q     <= 1'b0;
      lap_sec_q <= '0;
      lap_min_q <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      clr_q     <= clr_d;
      lap_sec_q <= lap_sec_d;
      lap_min_q <= lap_min_d;
    end
  end

  // Display mux: frozen lap value while in LAP, live counter otherwise
  always_comb begin
    lap_active = (state_q == ST_LAP);
    disp_sec   = lap_active ? lap_sec_q : sec_in;
    disp_min   = lap_active ? lap_min_q : min_in;
  end

  assign tick  = tick_q;
  assign clr   = clr_q;
  assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Directed self-checking bench for stopwatch_ctrl with
//               TICK_DIV=10 and DEBOUNCE_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start, btn_stop, btn_lap;
  logic [5:0] sec_in, min_in;
  logic       tick, clr, lap_active;
  logic [5:0] disp_sec, disp_min;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  // Event counters maintained away from the active edge
  int tick_cnt  = 0;
  int clr_cnt   = 0;
  int bad_tick  = 0;
  int both_high = 0;
  int t0, c0;

  stopwatch_ctrl #(
    .TICK_DIV       (10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .btn_lap   (btn_lap),
    .sec_in    (sec_in),
    .min_in    (min_in),
    .tick      (tick),
    .clr       (clr),
    .disp_sec  (disp_sec),
    .disp_min  (disp_min),
    .lap_active(lap_active),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Tally ticks/clears and flag illegal combinations on the falling edge
  always @(negedge clk) begin
    if (tick === 1'b1) tick_cnt++;
    if (clr === 1'b1) clr_cnt++;
    if (tick === 1'b1 && (state == 2'd0 || state == 2'd2)) bad_tick++;
    if (tick === 1'b1 && clr === 1'b1) both_high++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Assert a button set before an edge; after 7 edges the FSM has reacted
  task automatic press(input logic s, input logic p, input logic l);
    btn_start = s;
    btn_stop  = p;
    btn_lap   = l;
    repeat (7) cyc();
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_lap   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_lap   = 1'b0;
    sec_in    = 6'd17;
    min_in    = 6'd0;

    // Reset then idle
    repeat (3) cyc();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_clr", 32'(clr), 32'd0);
    chk("rst_lap_active", 32'(lap_active), 32'd0);
    rst_n = 1'b1;
    repeat (50) cyc();
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_ticks", 32'(tick_cnt), 32'd0);
    chk("idle_clr", 32'(clr), 32'd0);
    chk("idle_disp_sec", 32'(disp_sec), 32'd17);

    // Start: 2 sync + 4 debounce cycles, state changes on the 7th edge
    btn_start = 1'b1;
    repeat (6) cyc();
    chk("start_not_yet", 32'(state), 32'd0);
    cyc();
    chk("start_run", 32'(state), 32'd1);
    t0 = tick_cnt;
    repeat (3) cyc();
    btn_start = 1'b0;
    repeat (22) cyc();
    chk("run_2_ticks_in_25", 32'(tick_cnt - t0), 32'd2);

    // Pause keeps the fraction: stop asserted right after a tick edge
    for (int i = 0; i < 30; i++) begin
      if (tick === 1'b1) break;
      cyc();
    end
    chk("tick_seen", 32'(tick), 32'd1);
    press(1'b0, 1'b1, 1'b0);
    chk("pause_state", 32'(state), 32'd2);
    t0 = tick_cnt;
    repeat (40) cyc();
    chk("pause_no_ticks", 32'(tick_cnt - t0), 32'd0);
    chk("pause_hold", 32'(state), 32'd2);
    press(1'b1, 1'b0, 1'b0);
    chk("resume_run", 32'(state), 32'd1);
    chk("resume_tick_e0", 32'(tick), 32'd0);
    repeat (2) cyc();
    chk("resume_tick_e2", 32'(tick), 32'd0);
    cyc();
    chk("resume_tick_e3", 32'(tick), 32'd1);

    // Lap freeze
    sec_in = 6'd23;
    min_in = 6'd4;
    press(1'b0, 1'b0, 1'b1);
    chk("lap_state", 32'(state), 32'd3);
    chk("lap_active", 32'(lap_active), 32'd1);
    sec_in = 6'd30;
    t0 = tick_cnt;
    repeat (20) cyc();
    chk("lap_disp_sec", 32'(disp_sec), 32'd23);
    chk("lap_disp_min", 32'(disp_min), 32'd4);
    chk("lap_ticks_continue", 32'(tick_cnt - t0), 32'd2);
    press(1'b0, 1'b0, 1'b1);
    chk("unlap_state", 32'(state), 32'd1);
    chk("unlap_active", 32'(lap_active), 32'd0);
    chk("unlap_disp_sec", 32'(disp_sec), 32'd30);
    chk("unlap_disp_min", 32'(disp_min), 32'd4);

    // Clear from PAUSE
    repeat (10) cyc();
    press(1'b0, 1'b1, 1'b0);
    chk("clr_pause", 32'(state), 32'd2);
    repeat (10) cyc();
    c0 = clr_cnt;
    press(1'b0, 1'b0, 1'b1);
    chk("clr_idle", 32'(state), 32'd0);
    chk("clr_high", 32'(clr), 32'd1);
    cyc();
    chk("clr_low", 32'(clr), 32'd0);
    repeat (5) cyc();
    chk("clr_one_pulse", 32'(clr_cnt - c0), 32'd1);
    repeat (10) cyc();
    press(1'b0, 1'b1, 1'b0);
    repeat (5) cyc();
    chk("idle_stop_ignored", 32'(state), 32'd0);
    chk("idle_stop_no_clr", 32'(clr_cnt - c0), 32'd1);

    // Bounce: toggling every 2 cycles never reaches 4 stable samples
    repeat (10) cyc();
    for (int i = 0; i < 10; i++) begin
      btn_start = ~btn_start;
      repeat (2) cyc();
    end
    btn_start = 1'b0;
    repeat (10) cyc();
    chk("bounce_no_press", 32'(state), 32'd0);

    // Priority: stop wins over start in RUN
    press(1'b1, 1'b0, 1'b0);
    chk("prio_run", 32'(state), 32'd1);
    repeat (10) cyc();
    press(1'b1, 1'b1, 1'b0);
    chk("prio_stop_wins", 32'(state), 32'd2);

    // Asynchronous reset mid-operation
    repeat (10) cyc();
    press(1'b1, 1'b0, 1'b0);
    chk("pre_reset_run", 32'(state), 32'd1);
    repeat (3) cyc();
    t0 = tick_cnt;
    c0 = clr_cnt;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_tick", 32'(tick), 32'd0);
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (12) cyc();
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_no_ticks", 32'(tick_cnt - t0), 32'd0);
    chk("post_rst_no_clr", 32'(clr_cnt - c0), 32'd0);

    // Global invariants
    chk("no_tick_idle_pause", 32'(bad_tick), 32'd0);
    chk("no_tick_with_clr", 32'(both_high), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
